// File: rtl/vector_dispatch_pkg.sv
// Shared widths for the scalar-to-vector dispatch path.
package vector_dispatch_pkg;

    localparam int unsigned DATA_FROM_SCALAR_DEF = 96;
    localparam int unsigned INSTRUCTION_BITS_DEF = 32;

    // Instruction field occupies the top bits of each entry
    localparam int unsigned INSTR_FIELD_MSB = DATA_FROM_SCALAR_DEF - 1;
    localparam int unsigned INSTR_FIELD_LSB = DATA_FROM_SCALAR_DEF - INSTRUCTION_BITS_DEF;

endpackage

// File: rtl/vector_instr_queue.sv
// FIFO between the scalar core and the vector dispatch scoreboard; the head is
// presented first-word-fall-through and gated to zero when the queue is empty.
module vector_instr_queue
    import vector_dispatch_pkg::*;
#(
    parameter int unsigned DATA_FROM_SCALAR  = DATA_FROM_SCALAR_DEF,
    parameter int unsigned INSTRUCTION_BITS  = INSTRUCTION_BITS_DEF,
    parameter int unsigned DEPTH             = 4,
    parameter int unsigned ALMOST_FULL_LEVEL = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DATA_FROM_SCALAR-1:0]   data_in,
    output logic                          ready_scalar,
    output logic                          almost_full,
    input  logic                          flush,
    output logic                          valid_fifo,
    output logic [DATA_FROM_SCALAR-1:0]   instruction_to_issue,
    input  logic                          pop_data,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          overflow_err,
    output logic                          underflow_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [DATA_FROM_SCALAR-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] count_q;

    logic empty;
    logic full;
    logic push_acc;
    logic pop_acc;

    // Wrap bit distinguishes full from empty when the index bits match
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                      (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
    assign push_acc = push && !full;
    assign pop_acc  = pop_data && !empty;

    // Pointer and occupancy registers; flush outranks push and pop
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_acc, pop_acc})
                2'b10:   count_q <= count_q + PTR_W'(1);
                2'b01:   count_q <= count_q - PTR_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky protocol-violation flags survive flush
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (push && full) begin
                overflow_err <= 1'b1;
            end
            if (pop_data && empty) begin
                underflow_err <= 1'b1;
            end
        end
    end

    // Storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (!rst && !flush && push_acc) begin
            mem[wr_ptr[IDX_W-1:0]] <= data_in;
        end
    end

    assign instruction_to_issue = empty ? '0 : mem[rd_ptr[IDX_W-1:0]];
    assign valid_fifo           = !empty;
    assign ready_scalar         = !full;
    assign count                = count_q;
    assign almost_full          = (count_q >= PTR_W'(ALMOST_FULL_LEVEL));

endmodule

// File: tb/tb_vector_instr_queue.sv
// Directed self-checking bench for vector_instr_queue (DEPTH=4).
module tb_vector_instr_queue;

    localparam int unsigned DW = 96;

    logic          clk;
    logic          rst;
    logic          push;
    logic [DW-1:0] data_in;
    logic          ready_scalar;
    logic          almost_full;
    logic          flush;
    logic          valid_fifo;
    logic [DW-1:0] instruction_to_issue;
    logic          pop_data;
    logic [2:0]    count;
    logic          overflow_err;
    logic          underflow_err;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model_q[$];

    vector_instr_queue #(
        .DATA_FROM_SCALAR (96),
        .INSTRUCTION_BITS (32),
        .DEPTH            (4),
        .ALMOST_FULL_LEVEL(3)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .push                (push),
        .data_in             (data_in),
        .ready_scalar        (ready_scalar),
        .almost_full         (almost_full),
        .flush               (flush),
        .valid_fifo          (valid_fifo),
        .instruction_to_issue(instruction_to_issue),
        .pop_data            (pop_data),
        .count               (count),
        .overflow_err        (overflow_err),
        .underflow_err       (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus, then sample 1 time unit after the edge
    task automatic cycle(input logic p, input logic [DW-1:0] d, input logic po, input logic fl);
        push     = p;
        data_in  = d;
        pop_data = po;
        flush    = fl;
        @(posedge clk);
        #1;
        push     = 1'b0;
        pop_data = 1'b0;
        flush    = 1'b0;
        data_in  = '0;
    endtask

    task automatic check_state(input string tag, input int exp_cnt, input logic [DW-1:0] exp_head);
        check({tag, ".count"}, DW'(count), DW'(exp_cnt));
        check({tag, ".valid"}, DW'(valid_fifo), DW'(exp_cnt != 0));
        check({tag, ".head"}, instruction_to_issue, exp_head);
        check({tag, ".ready"}, DW'(ready_scalar), DW'(exp_cnt != 4));
        check({tag, ".afull"}, DW'(almost_full), DW'(exp_cnt >= 3));
    endtask

    initial begin
        rst = 1'b1;
        push = 1'b0;
        pop_data = 1'b0;
        flush = 1'b0;
        data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check_state("reset", 0, '0);
        check("reset.ovf", DW'(overflow_err), '0);
        check("reset.unf", DW'(underflow_err), '0);

        // Two pushes then two pops
        cycle(1'b1, 96'h1, 1'b0, 1'b0);
        check_state("pushA", 1, 96'h1);
        cycle(1'b1, 96'h2, 1'b0, 1'b0);
        check_state("pushB", 2, 96'h1);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check_state("pop1", 1, 96'h2);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check_state("pop2", 0, '0);

        // Fill to DEPTH, then push into a full queue
        cycle(1'b1, 96'h10, 1'b0, 1'b0);
        cycle(1'b1, 96'h11, 1'b0, 1'b0);
        cycle(1'b1, 96'h12, 1'b0, 1'b0);
        check_state("fill3", 3, 96'h10);
        cycle(1'b1, 96'h13, 1'b0, 1'b0);
        check_state("fill4", 4, 96'h10);
        check("fill4.ovf", DW'(overflow_err), '0);
        cycle(1'b1, 96'h14, 1'b0, 1'b0);
        check_state("push_full", 4, 96'h10);
        check("push_full.ovf", DW'(overflow_err), 96'h1);

        // Push and pop together at full: pop wins, push dropped
        cycle(1'b1, 96'h15, 1'b1, 1'b0);
        check_state("pushpop_full", 3, 96'h11);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check_state("drain1", 2, 96'h12);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check_state("drain2", 1, 96'h13);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check_state("drain3", 0, '0);
        check("drain3.unf", DW'(underflow_err), '0);

        // Pop while empty
        cycle(1'b0, '0, 1'b1, 1'b0);
        check_state("pop_empty", 0, '0);
        check("pop_empty.unf", DW'(underflow_err), 96'h1);

        // Push with pop at empty: push taken, no bypass
        cycle(1'b1, 96'h7, 1'b1, 1'b0);
        check_state("pushpop_empty", 1, 96'h7);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check_state("pushpop_empty.drain", 0, '0);

        // Flush at count 3 with push and pop in the same cycle
        cycle(1'b1, 96'h20, 1'b0, 1'b0);
        cycle(1'b1, 96'h21, 1'b0, 1'b0);
        cycle(1'b1, 96'h22, 1'b0, 1'b0);
        check_state("preflush", 3, 96'h20);
        cycle(1'b1, 96'h23, 1'b1, 1'b1);
        check_state("flush", 0, '0);
        check("flush.ovf", DW'(overflow_err), 96'h1);
        check("flush.unf", DW'(underflow_err), 96'h1);
        cycle(1'b1, 96'h30, 1'b0, 1'b0);
        check_state("postflush", 1, 96'h30);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check_state("postflush.drain", 0, '0);

        // Interleaved traffic across pointer wrap against a queue model
        model_q.delete();
        for (int i = 0; i < 20; i++) begin
            logic          p;
            logic          po;
            logic [DW-1:0] d;
            logic          pa;
            logic          pb;
            p  = ((i % 3) != 2) || (i < 4);
            po = ((i % 2) == 1) && (i >= 3);
            d  = {32'hA000_0000 + 32'(i), 32'h0, 32'(i * 7)};
            pa = p && (model_q.size() < 4);
            pb = po && (model_q.size() > 0);
            cycle(p, d, po, 1'b0);
            if (pb) void'(model_q.pop_front());
            if (pa) model_q.push_back(d);
            check_state($sformatf("wrap%0d", i), model_q.size(),
                        (model_q.size() > 0) ? model_q[0] : '0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
